mmio_port_bank: RTL
===================

// Module: mmio_port_bank
// PURPOSE
// Parametrised memory-mapped GPIO bank for the JZJCoreF family: NUM_PORTS 32-bit ports, each with output
// register, direction register, input synchronizer and rise/fall edge-pending registers (write-1-to-clear).
// Sits behind the memory controller; replaces the fixed eight in/out port pairs with a scalable bank plus interrupt.
// PARAMETERS
// NUM_PORTS     8              number of ports, 1..16
// BASE_ADDRESS  32'hFFFFFF00   byte address of port 0 register block; must be 16*NUM_PORTS aligned
// SYNC_STAGES   2              input synchronizer depth, >= 2
// PORTS
// clock         in   1               system clock, all state on rising edge
// reset         in   1               asynchronous, active-high; clears all state
// address       in   32              byte address from memory controller
// writeData     in   32              store data, bus byte lane k = writeData[8k+7:8k] = address offset k
// byteEnable    in   4               per-lane write enable
// writeEnable   in   1               store strobe, one cycle
// readEnable    in   1               load strobe, one cycle
// hit           out  1               combinational: address inside bank window
// readData      out  32              registered load data, bus lane order
// portInput     in   32*NUM_PORTS    external inputs, port n = [32n+31:32n]
// portOutput    out  32*NUM_PORTS    output registers
// portDirection out  32*NUM_PORTS    direction registers, 1 = drive (used by external tristate logic)
// interrupt     out  1               registered OR of all pending bits
// BEHAVIOUR
// - Window: hit = BASE_ADDRESS <= address < BASE_ADDRESS+16*NUM_PORTS; address[1:0] ignored (word access).
// - Per port n at BASE+16n: +0 DATA (rd: synced input, wr: output reg), +4 DIR (rd/wr), +8 RISE (rd, W1C), +C FALL (rd, W1C).
// - Byte swap: bus lane k <-> register bits [31-8k -: 8]; so bus byte at offset 0 = register[31:24].
// - Writes: take effect at the edge where writeEnable & hit; only enabled lanes change. No hit -> no change.
// - Reads: readData updates at edge where readEnable & hit (1-cycle latency); holds otherwise; no-hit read holds.
// - Read and write same cycle, same register: readData returns pre-write value.
// - Synchronizer: SYNC_STAGES flops per bit; DATA read reflects portInput sampled SYNC_STAGES edges earlier.
// - Edge detect: compares last sync stage with one extra delay flop; 0->1 sets RISE bit, 1->0 sets FALL bit.
// - Pending set and W1C clear on same bit same cycle: set wins (bit stays 1). Writing 0 bits: no effect.
// - interrupt = registered |(all RISE|FALL); asserts 1 cycle after a pending bit sets, drops 1 cycle after last clear.
// - Reset (any time, incl. mid-access): portOutput, portDirection, RISE, FALL, readData, interrupt,
//   sync and delay flops -> 0. No edges flagged on first cycles after reset for inputs held at 0;
//   inputs held at 1 through reset flag RISE once, SYNC_STAGES+1 cycles after reset release.
// - No state machine beyond per-bit pipelines; all widths exact, no arithmetic except window compare
//   (compute address-BASE_ADDRESS in 32 bits, check < 16*NUM_PORTS; no wrap past 0xFFFFFFFF).
// TESTING
// - Reset: after reset release all outputs 0; read of BASE+4 -> readData 0 next cycle, interrupt 0.
// - Byte write: write 0xAABBCCDD to BASE+0 with byteEnable 4'b0001 -> portOutput[31:0] = 0xDD000000;
//   then full write 0x11223344 -> portOutput[31:0] = 0x44332211; read back BASE+4 of port 1 unaffected.
// - Sync latency: portInput port 2 = 0x0000_0001 at cycle t -> DATA read of BASE+0x20 returns 0x01000000 only for
//   reads at or after edge t+SYNC_STAGES; RISE(BASE+0x28) bit0 set one edge later; interrupt 1 edge after that.
// - W1C race: RISE bit0 set; write 0x01000000 to BASE+0x28 same cycle as a new rising edge on bit0 -> bit stays 1;
//   repeat with no new edge -> bit clears, interrupt drops next cycle.
// - Window: NUM_PORTS=8, write to BASE-4 and BASE+0x80 -> hit 0, no register changes, readData holds.
// - Reset mid-operation: assert reset in cycle after a write/read strobe pair -> all state 0 immediately
//   (asynchronous), pending write lost, readData 0.

Source files
------------

// File: rtl/mmio_port_bank_if.sv
// mmio_port_bank_if
//   Load/store bus between the memory controller (master) and a memory-mapped
//   peripheral (slave).
//   address     byte address, word accesses (address[1:0] ignored by slaves)
//   writeData   store data, bus byte lane k = writeData[8k+7:8k]
//   byteEnable  per-lane write enable
//   writeEnable store strobe, one cycle
//   readEnable  load strobe, one cycle
//   hit         slave claims the address (combinational)
//   readData    registered load data, one cycle after readEnable
interface mmio_port_bank_if;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [3:0]  byteEnable;
  logic        writeEnable;
  logic        readEnable;
  logic        hit;
  logic [31:0] readData;

  modport master (
    output address, writeData, byteEnable, writeEnable, readEnable,
    input  hit, readData
  );

  modport slave (
    input  address, writeData, byteEnable, writeEnable, readEnable,
    output hit, readData
  );
endinterface

// File: rtl/mmio_port_bank.sv
// mmio_port_bank
//   Memory-mapped GPIO bank: NUM_PORTS 32-bit ports, each with an output
//   register, a direction register, an input synchronizer and rise/fall
//   edge-pending registers (write-1-to-clear). Port n occupies 16 bytes at
//   BASE_ADDRESS + 16n: +0 DATA, +4 DIR, +8 RISE, +C FALL.
//   clock          system clock, rising edge
//   reset          asynchronous, active-high
//   bus            load/store slave port (see mmio_port_bank_if)
//   portInput      external inputs, port n = [32n+31:32n]
//   portOutput     output registers
//   portDirection  direction registers, 1 = drive
//   interrupt      registered OR of every pending edge bit
module mmio_port_bank #(
  parameter int          NUM_PORTS    = 8,
  parameter logic [31:0] BASE_ADDRESS = 32'hFFFFFF00,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  mmio_port_bank_if.slave          bus,
  input  logic [32*NUM_PORTS-1:0]  portInput,
  output logic [32*NUM_PORTS-1:0]  portOutput,
  output logic [32*NUM_PORTS-1:0]  portDirection,
  output logic                     interrupt
);

  localparam int          IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [31:0] WINDOW = 32'(16 * NUM_PORTS);

  // The bus is little-endian by lane, the registers big-endian by byte.
  function automatic logic [31:0] laneSwap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // Subtracting first means addresses below the base wrap to huge offsets
  // and the top of the address space never wraps back into the window.
  logic [31:0]      offset;
  logic [IDX_W-1:0] portSel;
  logic [1:0]       regSel;
  logic             writeHit;
  logic [31:0]      wrSwapped;
  logic [31:0]      wrMask;

  assign offset    = bus.address - BASE_ADDRESS;
  assign bus.hit   = offset < WINDOW;
  assign portSel   = offset[4 +: IDX_W];
  assign regSel    = offset[3:2];
  assign writeHit  = bus.writeEnable & bus.hit;
  assign wrSwapped = laneSwap(bus.writeData);
  assign wrMask    = {{8{bus.byteEnable[0]}}, {8{bus.byteEnable[1]}},
                      {8{bus.byteEnable[2]}}, {8{bus.byteEnable[3]}}};

  logic [32*NUM_PORTS-1:0] syncFlat;
  logic [32*NUM_PORTS-1:0] riseFlat;
  logic [32*NUM_PORTS-1:0] fallFlat;

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
    logic [31:0] outReg, dirReg, riseReg, fallReg, delayReg;
    logic [31:0] syncReg [SYNC_STAGES];
    logic        selected;
    logic [31:0] riseSet, fallSet, riseClr, fallClr;

    assign selected = writeHit && (portSel == IDX_W'(n));
    assign riseSet  = syncReg[SYNC_STAGES-1] & ~delayReg;
    assign fallSet  = ~syncReg[SYNC_STAGES-1] & delayReg;
    assign riseClr  = (selected && regSel == 2'd2) ? (wrSwapped & wrMask) : 32'h0;
    assign fallClr  = (selected && regSel == 2'd3) ? (wrSwapped & wrMask) : 32'h0;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        outReg   <= '0;
        dirReg   <= '0;
        riseReg  <= '0;
        fallReg  <= '0;
        delayReg <= '0;
        for (int s = 0; s < SYNC_STAGES; s++) syncReg[s] <= '0;
      end else begin
        syncReg[0] <= portInput[32*n +: 32];
        for (int s = 1; s < SYNC_STAGES; s++) syncReg[s] <= syncReg[s-1];
        delayReg <= syncReg[SYNC_STAGES-1];
        if (selected && regSel == 2'd0) outReg <= (outReg & ~wrMask) | (wrSwapped & wrMask);
        if (selected && regSel == 2'd1) dirReg <= (dirReg & ~wrMask) | (wrSwapped & wrMask);
        // A new edge in the same cycle as its clear keeps the bit set.
        riseReg <= (riseReg & ~riseClr) | riseSet;
        fallReg <= (fallReg & ~fallClr) | fallSet;
      end
    end

    assign portOutput[32*n +: 32]    = outReg;
    assign portDirection[32*n +: 32] = dirReg;
    assign syncFlat[32*n +: 32]      = syncReg[SYNC_STAGES-1];
    assign riseFlat[32*n +: 32]      = riseReg;
    assign fallFlat[32*n +: 32]      = fallReg;
  end

  logic [31:0] regWord;

  always_comb begin
    regWord = '0;
    case (regSel)
      2'd0:    regWord = syncFlat[{portSel, 5'b0} +: 32];
      2'd1:    regWord = portDirection[{portSel, 5'b0} +: 32];
      2'd2:    regWord = riseFlat[{portSel, 5'b0} +: 32];
      default: regWord = fallFlat[{portSel, 5'b0} +: 32];
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.readData <= '0;
      interrupt    <= 1'b0;
    end else begin
      if (bus.readEnable && bus.hit) bus.readData <= laneSwap(regWord);
      interrupt <= |riseFlat | |fallFlat;
    end
  end

endmodule
